// File: rtl/vram_scheduler_if.sv
// vram_scheduler_if: CPU request/acknowledge bus into the VRAM scheduler
interface vram_scheduler_if #(parameter int ADDR_W = 14);
  logic req;
  logic we;
  logic [ADDR_W-1:0] addr;
  logic [7:0] wdata;
  logic ack;
  logic [7:0] rdata;
  modport master(output req, we, addr, wdata, input ack, rdata);
  modport slave(input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/vram_scheduler.sv
// vram_scheduler: shares the single-port VRAM between tile fetch slots and a CPU requester
module vram_scheduler #(
  parameter int ADDR_W = 14,
  parameter logic [ADDR_W-1:0] NAME_BASE = 14'h3800,
  parameter logic [ADDR_W-1:0] PATTERN_BASE = 14'h0000
) (
  input  logic clk,
  input  logic reset,
  input  logic signed [8:0] xPos,
  input  logic signed [8:0] yPos,
  vram_scheduler_if.slave cpu,
  output logic [ADDR_W-1:0] ram_addr,
  output logic ram_we,
  output logic [7:0] ram_wdata,
  input  logic [7:0] ram_rdata,
  output logic [7:0] tile_name,
  output logic [7:0] tile_pattern,
  output logic pattern_valid
);
  typedef enum logic {IDLE, ACK} state_t;
  state_t state;
  logic [8:0] xp;
  logic [2:0] slot;
  logic in_win, name_slot, pat_slot, grant, rd_q;
  logic [7:0] name_latch, rdata_q;
  assign xp = $unsigned(xPos) + 9'd8;
  assign in_win = !xp[8] && !yPos[8] && yPos[7:0] < 8'd192;
  assign slot = xp[2:0];
  assign name_slot = in_win && slot == 3'd0;
  assign pat_slot = in_win && slot == 3'd2;
  // gating with reset keeps a write from slipping through in the reset cycle
  assign grant = !reset && state == IDLE && cpu.req && !name_slot && !pat_slot;
  always_comb begin
    ram_addr = grant ? cpu.addr
             : name_slot ? NAME_BASE + ADDR_W'({yPos[7:3], xp[7:3]})
             : pat_slot ? PATTERN_BASE + ADDR_W'({name_latch, yPos[2:0]})
             : '0;
    ram_we = grant && cpu.we;
    ram_wdata = grant ? cpu.wdata : 8'h00;
  end
  assign cpu.ack = state == ACK;
  // read data arrives during the ack cycle, so it is forwarded and also held
  assign cpu.rdata = (state == ACK && rd_q) ? ram_rdata : rdata_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rd_q <= 1'b0;
      rdata_q <= 8'h00;
      name_latch <= 8'h00;
      tile_name <= 8'h00;
      tile_pattern <= 8'h00;
      pattern_valid <= 1'b0;
    end else begin
      state <= grant ? ACK : IDLE;
      if (grant) rd_q <= !cpu.we;
      if (state == ACK && rd_q) rdata_q <= ram_rdata;
      if (in_win && slot == 3'd1) name_latch <= ram_rdata;
      pattern_valid <= in_win && slot == 3'd3;
      if (in_win && slot == 3'd3) begin
        tile_name <= name_latch;
        tile_pattern <= ram_rdata;
      end
    end
  end
endmodule
